// File: rtl/rs232_rx.sv
// RS-232 8-bit receiver: 2-flop synchronizer, mid-bit sampling, stop check.
// Define RS232_RX_PARITY_EN to expect and check an even-parity bit after bit 7.
module rs232_rx #(
  parameter int uart_bps = 9600,
  parameter int clk_freq = 50000000
) (
  input  logic       system_clk,
  input  logic       system_rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam int BAUD_CNT_MAX = clk_freq / uart_bps;
  localparam int CW = $clog2(BAUD_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(BAUD_CNT_MAX / 2);

`ifdef RS232_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic flag_q, flag_d;
  logic ferr_q, ferr_d;
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic fall, mid, last, stop_ok;

`ifdef RS232_RX_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  assign fall = rx_s3_q & ~rx_s2_q;
  assign mid = (cnt_q == CNT_MID);
  assign last = (cnt_q == CNT_LAST);

`ifdef RS232_RX_PARITY_EN
  assign stop_ok = rx_s2_q & ~par_err_q;
`else
  assign stop_ok = rx_s2_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    flag_d = 1'b0;
    ferr_d = 1'b0;
`ifdef RS232_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef RS232_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (fall) state_d = START;
      end
      START: begin
        if (mid && rx_s2_q) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mid) shift_d = {rx_s2_q, shift_q[7:1]};
        if (last) begin
          bit_d = bit_q + 3'd1;
`ifdef RS232_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef RS232_RX_PARITY_EN
      PARITY: begin
        // Even parity: data plus parity bit must hold an even count of ones
        if (mid) par_err_d = ^{shift_q, rx_s2_q};
        if (last) state_d = STOP;
      end
`endif
      STOP: begin
        if (mid) begin
          state_d = IDLE;
          cnt_d = '0;
          if (stop_ok) begin
            data_d = shift_q;
            flag_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      flag_q <= 1'b0;
      ferr_q <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
`ifdef RS232_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      flag_q <= flag_d;
      ferr_q <= ferr_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
`ifdef RS232_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign po_data = data_q;
  assign po_flag = flag_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx: directed and random frames against a frame-level model.
// Runs with a scaled clock (100 clocks per bit) to keep simulation short.
module tb_rs232_rx;

  localparam int BPS = 9600;
  localparam int CLK = 960000;
  localparam int BIT = CLK / BPS;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic [7:0] po_data;
  logic po_flag;
  logic frame_err;

  int checks = 0;
  int errors = 0;
  int flag_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  logic flag_prev = 1'b0;
  logic ferr_prev = 1'b0;
  logic [7:0] last_got = 8'h00;
  logic [7:0] exp_data = 8'h00;

  rs232_rx #(
    .uart_bps(BPS),
    .clk_freq(CLK)
  ) dut (
    .system_clk(clk),
    .system_rst(rst),
    .rx(rx),
    .po_data(po_data),
    .po_flag(po_flag),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (po_flag) begin
      flag_cnt++;
      last_got = po_data;
    end
    if (frame_err) ferr_cnt++;
    if (po_flag && frame_err) both_cnt++;
    if ((po_flag && flag_prev) || (frame_err && ferr_prev)) long_cnt++;
    flag_prev = po_flag;
    ferr_prev = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic stop_ok,
                           input logic par, input int gap);
    int f0;
    int e0;
    logic ok;
    f0 = flag_cnt;
    e0 = ferr_cnt;
    ok = stop_ok;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RS232_RX_PARITY_EN
    ok = ok && (par == ^d);
    send_bit(par);
`endif
    send_bit(stop_ok);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    chk("flag_pulses", flag_cnt - f0, {31'd0, ok});
    chk("ferr_pulses", ferr_cnt - e0, {31'd0, !ok});
    if (ok) begin
      exp_data = d;
      chk("rx_byte", {24'd0, last_got}, {24'd0, d});
    end
    chk("po_data", {24'd0, po_data}, {24'd0, exp_data});
  endtask

  initial begin
    int f0;
    int e0;
    logic [7:0] d;
    logic s;
    logic p;
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_po_data", {24'd0, po_data}, 32'h0);
    chk("rst_po_flag", {31'd0, po_flag}, 32'h0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'h0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    run_frame(8'h55, 1'b1, ^8'h55, BIT);
    run_frame(8'h00, 1'b1, 1'b0, 0);
    run_frame(8'hFF, 1'b1, ^8'hFF, BIT);

    f0 = flag_cnt;
    e0 = ferr_cnt;
    rx = 1'b0;
    repeat (BIT / 5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("glitch_flag", flag_cnt - f0, 32'd0);
    chk("glitch_ferr", ferr_cnt - e0, 32'd0);
    run_frame(8'hA3, 1'b1, ^8'hA3, BIT);

    run_frame(8'h3C, 1'b0, ^8'h3C, 2 * BIT);

    f0 = flag_cnt;
    e0 = ferr_cnt;
    d = 8'hC7;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_po_data", {24'd0, po_data}, 32'h0);
    rst = 1'b0;
    exp_data = 8'h00;
    repeat (3 * BIT) @(negedge clk);
    chk("abort_flag", flag_cnt - f0, 32'd0);
    chk("abort_ferr", ferr_cnt - e0, 32'd0);
    run_frame(8'h12, 1'b1, ^8'h12, BIT);

`ifdef RS232_RX_PARITY_EN
    run_frame(8'h07, 1'b1, 1'b0, BIT);
    run_frame(8'h07, 1'b1, 1'b1, BIT);
`endif

    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      run_frame(d, s, p, s ? $urandom_range(0, BIT) : BIT);
    end

    chk("flag_and_ferr_together", both_cnt, 32'd0);
    chk("pulse_longer_than_1", long_cnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
